operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Decode/operand-fetch stage between instruction fetch and execute.
- Takes one RV32I instruction per handshake and extracts rs1/rs2/rd.
- Drives the register file's combinational read ports and returns registered operands to execute.
- Tracks pending register writes in a per-register scoreboard and stalls on read-after-write hazards. Optionally bypasses the writeback value.

Parameters:
REG_ADDR_WIDTH, 5, register index width (2**REG_ADDR_WIDTH registers)
CNT_WIDTH, 2, width of per-register pending-write counter (max 2**CNT_WIDTH-1 in flight per rd)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
flush  in  1  kill the instruction held in the output register
in_valid  in  1  fetch has an instruction
in_ready  out  1  stage accepts in_instr this cycle
in_instr  in  32  instruction word
in_pc  in  32  instruction address
rf_addr_rs1  out  REG_ADDR_WIDTH  = in_instr[19:15]
rf_addr_rs2  out  REG_ADDR_WIDTH  = in_instr[24:20]
rf_data_rs1  in  32  combinational read data
rf_data_rs2  in  32  combinational read data
wb_valid  in  1  writeback commits this cycle (same signal as reg file write enable)
wb_rd  in  REG_ADDR_WIDTH  writeback destination
wb_data  in  32  writeback value
out_valid  out  1  operands valid to execute
out_ready  in  1  execute accepts
out_pc, out_instr  out  32 each  registered copies
out_rs1_val, out_rs2_val  out  32 each  resolved operands
out_rd  out  REG_ADDR_WIDTH  destination, 0 when the instruction writes no register

Behaviour:
- Reset: all outputs 0, out_valid=0, all scoreboard counters 0. Reset wins over every other event.
- Operand use by opcode in_instr[6:0]:
  - LUI 0110111, AUIPC 0010111, JAL 1101111: rd only.
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011: rs1, rd.
  - BRANCH 1100011, STORE 0100011: rs1, rs2.
  - OP 0110011: rs1, rs2, rd.
  - Anything else: no operands, rd=0.
- Register x0 is never hazarded, never scoreboarded, and always reads 0.
- Hazard on a used source rs when cnt[rs]!=0, subject to bypass (Optional Feature).
- Structural stall when rd uses the scoreboard and cnt[rd] is at its maximum.
- in_ready = !reset && !flush && !stall && (!out_valid || out_ready).
- Issue = in_valid && in_ready.
- On issue, the output register loads on the next edge: pc, instr, operands, rd; out_valid=1. Latency is 1 cycle.
- If out_valid && out_ready && !issue, out_valid goes to 0. Held data is unchanged while out_valid && !out_ready.
- Scoreboard, per register r, same edge: cnt[r] += (issue && rd==r) - (wb_valid && wb_rd==r). A simultaneous increment and decrement leaves the count unchanged.
  - Decrement when cnt[r]==0 saturates at 0 (wb from an untracked source).
  - wb_rd==0 is ignored.
- Flush:
  - out_valid goes to 0 next edge, and no issue occurs that cycle.
  - If out_valid was 1, the held out_rd count is decremented, combined with any wb decrement in the same cycle.
  - Instructions already past this stage must still produce their writeback.
- Fetch must hold in_instr/in_pc stable while in_valid && !in_ready.

Optional Feature:
- Macro OPERAND_FETCH_BYPASS_EN.
- Defined: a source with cnt[rs]==1 and wb_valid && wb_rd==rs is not a hazard; its operand is taken from wb_data instead of rf_data.
- Undefined: any nonzero count stalls. Because the reg file reads combinationally, the stall lasts until the cycle after the writeback edge.

Decomposition:
- Shared package rv32_pkg:
  - opcode constants (OPC_LUI, OPC_OP, ...)
  - REG_ADDR_WIDTH default
  - field-slice constants for rs1/rs2/rd
- Sub-module operand_scoreboard: counters, inc/dec ports, per-register busy and "count==1" outputs.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3) with rf x1=5, x2=7, out_ready=1 -> next cycle out_valid=1, out_rs1_val=5, out_rs2_val=7, out_rd=3; cnt[3]=1.
- ADDI x5,x0,1 then ADD x6,x5,x5, no writeback -> second instruction stalls (in_ready=0). Without the macro, wb x5=1 releases it one cycle after wb. With the macro, it issues in the wb cycle with both operands =1.
- out_ready=0 for 4 cycles with out_valid=1 -> outputs stable, in_ready=0; out_ready=1 -> next instruction accepted the same cycle.
- Issue three writes to x7 with CNT_WIDTH=2 -> the fourth writer stalls until one wb to x7; issue and wb to x7 in the same cycle -> cnt unchanged.
- flush while holding ADD rd=4 -> out_valid=0 next edge, cnt[4] back to prior value, no issue that cycle.
- Reset asserted mid-stall with cnt[5]=2 -> all counters 0, out_valid=0; after release, a reader of x5 issues without stall.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I decode constants: opcodes, register field positions, operand-use decode.
// Combinational helpers only; no latency and no flow control of its own.
package rv32_pkg;

    localparam int REG_ADDR_WIDTH_DEF = 5;

    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB  = 7;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic rs1;
        logic rs2;
        logic rd;
    } opnd_use_t;

    function automatic opnd_use_t decode_use(input logic [6:0] opc);
        opnd_use_t u;
        u = '0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL:      u = '{rs1: 1'b0, rs2: 1'b0, rd: 1'b1};
            OPC_JALR, OPC_LOAD, OPC_OP_IMM:   u = '{rs1: 1'b1, rs2: 1'b0, rd: 1'b1};
            OPC_BRANCH, OPC_STORE:            u = '{rs1: 1'b1, rs2: 1'b1, rd: 1'b0};
            OPC_OP:                           u = '{rs1: 1'b1, rs2: 1'b1, rd: 1'b1};
            default:                          u = '0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/operand_scoreboard.sv
// Per-register pending-write counters: one increment and two saturating decrements per cycle.
// Counts update on the clock edge after the request; flow control is left to the caller (full flag).
// Register 0 is hardwired to an empty count.
module operand_scoreboard
    import rv32_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH      = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        inc_en,
    input  logic [REG_ADDR_WIDTH-1:0]   inc_addr,
    input  logic                        dec_a_en,
    input  logic [REG_ADDR_WIDTH-1:0]   dec_a_addr,
    input  logic                        dec_b_en,
    input  logic [REG_ADDR_WIDTH-1:0]   dec_b_addr,
    output logic [2**REG_ADDR_WIDTH-1:0] busy,
    output logic [2**REG_ADDR_WIDTH-1:0] one,
    output logic [2**REG_ADDR_WIDTH-1:0] full
);

    localparam int NREG = 2**REG_ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] cnt_q [NREG];

    // Two decrements can hit one register (writeback plus flush of the held writer).
    function automatic logic [CNT_WIDTH-1:0] next_cnt(
        input logic [CNT_WIDTH-1:0] cur,
        input logic                 inc,
        input logic                 da,
        input logic                 db
    );
        logic [CNT_WIDTH:0] up;
        logic [CNT_WIDTH:0] dn;
        up = {1'b0, cur} + (CNT_WIDTH+1)'(inc);
        dn = (CNT_WIDTH+1)'(da) + (CNT_WIDTH+1)'(db);
        if (up > dn) begin
            return CNT_WIDTH'(up - dn);
        end
        return '0;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            cnt_q[0] <= '0;
            for (int r = 1; r < NREG; r++) begin
                cnt_q[r] <= next_cnt(cnt_q[r],
                                     inc_en   && (inc_addr   == REG_ADDR_WIDTH'(r)),
                                     dec_a_en && (dec_a_addr == REG_ADDR_WIDTH'(r)),
                                     dec_b_en && (dec_b_addr == REG_ADDR_WIDTH'(r)));
            end
        end
    end

    always_comb begin
        busy = '0;
        one  = '0;
        full = '0;
        for (int r = 1; r < NREG; r++) begin
            busy[r] = (cnt_q[r] != '0);
            one[r]  = (cnt_q[r] == CNT_WIDTH'(1));
            full[r] = (cnt_q[r] == CNT_MAX);
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand fetch: reads rs1/rs2, stalls on RAW hazards via scoreboard (OPERAND_FETCH_BYPASS_EN adds wb bypass).
// Latency 1 cycle from issue to out_valid.
// Backpressure: in_ready drops on hazard, full counter, flush, or held output not accepted.
module operand_fetch
    import rv32_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH      = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_instr,
    input  logic [31:0]               in_pc,
    output logic [REG_ADDR_WIDTH-1:0] rf_addr_rs1,
    output logic [REG_ADDR_WIDTH-1:0] rf_addr_rs2,
    input  logic [31:0]               rf_data_rs1,
    input  logic [31:0]               rf_data_rs2,
    input  logic                      wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [31:0]               wb_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_pc,
    output logic [31:0]               out_instr,
    output logic [31:0]               out_rs1_val,
    output logic [31:0]               out_rs2_val,
    output logic [REG_ADDR_WIDTH-1:0] out_rd
);

    localparam int NREG = 2**REG_ADDR_WIDTH;

`ifdef OPERAND_FETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    opnd_use_t                 use_f;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd_eff;
    logic                      rs1_used, rs2_used;
    logic                      rs1_byp, rs2_byp;
    logic                      rs1_haz, rs2_haz;
    logic                      rd_full;
    logic                      stall;
    logic                      issue;
    logic                      flush_dec;
    logic [31:0]               rs1_val, rs2_val;
    logic [NREG-1:0]           busy, one, full;

    assign use_f       = decode_use(in_instr[6:0]);
    assign rs1         = in_instr[RS1_LSB +: REG_ADDR_WIDTH];
    assign rs2         = in_instr[RS2_LSB +: REG_ADDR_WIDTH];
    assign rf_addr_rs1 = rs1;
    assign rf_addr_rs2 = rs2;
    assign rd_eff      = use_f.rd ? in_instr[RD_LSB +: REG_ADDR_WIDTH] : '0;

    assign rs1_used = use_f.rs1 && (rs1 != '0);
    assign rs2_used = use_f.rs2 && (rs2 != '0);

    // The reg file is only written at the wb edge, so a sole pending writer committing now is forwarded.
    assign rs1_byp = BYPASS && one[rs1] && wb_valid && (wb_rd == rs1);
    assign rs2_byp = BYPASS && one[rs2] && wb_valid && (wb_rd == rs2);

    assign rs1_haz = rs1_used && busy[rs1] && !rs1_byp;
    assign rs2_haz = rs2_used && busy[rs2] && !rs2_byp;
    assign rd_full = (rd_eff != '0) && full[rd_eff];
    assign stall   = rs1_haz || rs2_haz || rd_full;

    assign in_ready  = !reset && !flush && !stall && (!out_valid || out_ready);
    assign issue     = in_valid && in_ready;
    assign flush_dec = flush && out_valid;

    assign rs1_val = !rs1_used ? 32'd0 : (rs1_byp ? wb_data : rf_data_rs1);
    assign rs2_val = !rs2_used ? 32'd0 : (rs2_byp ? wb_data : rf_data_rs2);

    operand_scoreboard #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_sb (
        .clock      (clock),
        .reset      (reset),
        .inc_en     (issue),
        .inc_addr   (rd_eff),
        .dec_a_en   (wb_valid),
        .dec_a_addr (wb_rd),
        .dec_b_en   (flush_dec),
        .dec_b_addr (out_rd),
        .busy       (busy),
        .one        (one),
        .full       (full)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_instr   <= '0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_rd      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (issue) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_instr   <= in_instr;
            out_rs1_val <= rs1_val;
            out_rs2_val <= rs2_val;
            out_rd      <= rd_eff;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: hazards, backpressure, counter saturation, flush and reset.
module tb_operand_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rf_addr_rs1, rf_addr_rs2;
    logic [31:0] rf_data_rs1, rf_data_rs2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc, out_instr, out_rs1_val, out_rs2_val;
    logic [4:0]  out_rd;

    int errors = 0;
    int checks = 0;

    logic        rf_init;
    logic [31:0] rf [32];

    always #5 clock = ~clock;

    operand_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .rf_addr_rs1 (rf_addr_rs1),
        .rf_addr_rs2 (rf_addr_rs2),
        .rf_data_rs1 (rf_data_rs1),
        .rf_data_rs2 (rf_data_rs2),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_rs1_val (out_rs1_val),
        .out_rs2_val (out_rs2_val),
        .out_rd      (out_rd)
    );

    // Register file model: combinational read, write at the writeback edge.
    always @(posedge clock) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
            rf[1] <= 32'd5;
            rf[2] <= 32'd7;
        end else if (wb_valid && wb_rd != 5'd0) begin
            rf[wb_rd] <= wb_data;
        end
    end
    assign rf_data_rs1 = (rf_addr_rs1 == 5'd0) ? 32'd0 : rf[rf_addr_rs1];
    assign rf_data_rs2 = (rf_addr_rs2 == 5'd0) ? 32'd0 : rf[rf_addr_rs2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; rf_init = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_instr = '0; in_pc = '0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
        tick(); tick();
        rf_init = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0; #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ADD x3,x1,x2
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h100; #1;
        chk("add_addr_rs1", {27'd0, rf_addr_rs1}, 32'd1);
        chk("add_addr_rs2", {27'd0, rf_addr_rs2}, 32'd2);
        tick();
        in_valid = 1'b0;
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_rs1", out_rs1_val, 32'd5);
        chk("add_rs2", out_rs2_val, 32'd7);
        chk("add_rd", {27'd0, out_rd}, 32'd3);
        chk("add_pc", out_pc, 32'h100);
        chk("add_instr", out_instr, 32'h002081B3);
        chk("add_cnt3", {30'd0, dut.u_sb.cnt_q[3]}, 32'd1);
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'd12;
        tick();
        wb_valid = 1'b0;
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("wb_cnt3", {30'd0, dut.u_sb.cnt_q[3]}, 32'd0);
        // Writeback to an untracked register saturates at zero
        wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'd0;
        tick();
        wb_valid = 1'b0;
        chk("sat_cnt10", {30'd0, dut.u_sb.cnt_q[10]}, 32'd0);

        // ADDI x5,x0,1 then ADD x6,x5,x5
        in_valid = 1'b1; in_instr = 32'h00100293; in_pc = 32'h200;
        tick();
        chk("addi5_cnt5", {30'd0, dut.u_sb.cnt_q[5]}, 32'd1);
        in_instr = 32'h00528333; in_pc = 32'h204; #1;
        chk("raw_stall", {31'd0, in_ready}, 32'd0);
        tick();
        chk("raw_stall2", {31'd0, in_ready}, 32'd0);
        chk("raw_out_drained", {31'd0, out_valid}, 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'd1; #1;
`ifdef OPERAND_FETCH_BYPASS_EN
        chk("raw_wb_cycle_ready", {31'd0, in_ready}, 32'd1);
        tick();
        wb_valid = 1'b0;
`else
        chk("raw_wb_cycle_ready", {31'd0, in_ready}, 32'd0);
        tick();
        wb_valid = 1'b0; #1;
        chk("raw_after_wb_ready", {31'd0, in_ready}, 32'd1);
        tick();
`endif
        chk("raw_valid", {31'd0, out_valid}, 32'd1);
        chk("raw_rs1", out_rs1_val, 32'd1);
        chk("raw_rs2", out_rs2_val, 32'd1);
        chk("raw_rd", {27'd0, out_rd}, 32'd6);
        chk("raw_cnt5", {30'd0, dut.u_sb.cnt_q[5]}, 32'd0);

        // Backpressure: ADD x6 held for 4 cycles, ADDI x8,x0,3 waiting
        out_ready = 1'b0;
        in_instr = 32'h00300413; in_pc = 32'h208;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_rd", {27'd0, out_rd}, 32'd6);
            chk("bp_pc", out_pc, 32'h204);
            tick();
        end
        out_ready = 1'b1; #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_next_rd", {27'd0, out_rd}, 32'd8);
        chk("bp_next_rs1_x0", out_rs1_val, 32'd0);
        chk("bp_next_pc", out_pc, 32'h208);
        tick();

        // Three writers to x7 fill the 2-bit counter
        in_valid = 1'b1; in_instr = 32'h00100393; in_pc = 32'h300;
        tick(); tick(); tick();
        chk("x7_cnt_full", {30'd0, dut.u_sb.cnt_q[7]}, 32'd3);
        chk("x7_struct_stall", {31'd0, in_ready}, 32'd0);
        tick();
        chk("x7_still_stalled", {31'd0, in_ready}, 32'd0);
        chk("x7_out_drained", {31'd0, out_valid}, 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'd1; #1;
        chk("x7_wb_cycle_stall", {31'd0, in_ready}, 32'd0);
        tick();
        wb_valid = 1'b0; #1;
        chk("x7_cnt_after_wb", {30'd0, dut.u_sb.cnt_q[7]}, 32'd2);
        chk("x7_ready_after_wb", {31'd0, in_ready}, 32'd1);
        wb_valid = 1'b1; wb_rd = 5'd7;
        tick();
        wb_valid = 1'b0; in_valid = 1'b0;
        chk("x7_inc_dec_same", {30'd0, dut.u_sb.cnt_q[7]}, 32'd2);
        chk("x7_issue_valid", {31'd0, out_valid}, 32'd1);
        tick();

        // Flush while holding ADD x4,x1,x2
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00208233; in_pc = 32'h400;
        tick();
        chk("fl_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("fl_cnt4_before", {30'd0, dut.u_sb.cnt_q[4]}, 32'd1);
        flush = 1'b1; in_instr = 32'h00100493; in_pc = 32'h404; #1;
        chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_cnt4", {30'd0, dut.u_sb.cnt_q[4]}, 32'd0);
        chk("fl_cnt9_no_issue", {30'd0, dut.u_sb.cnt_q[9]}, 32'd0);
        out_ready = 1'b1;

        // Reset mid-stall with cnt[5]=2
        in_valid = 1'b1; in_instr = 32'h00100293; in_pc = 32'h500;
        tick(); tick();
        in_instr = 32'h00528333; in_pc = 32'h508; #1;
        chk("rs_cnt5", {30'd0, dut.u_sb.cnt_q[5]}, 32'd2);
        chk("rs_stall", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        tick();
        chk("rs_cnt5_clr", {30'd0, dut.u_sb.cnt_q[5]}, 32'd0);
        chk("rs_cnt7_clr", {30'd0, dut.u_sb.cnt_q[7]}, 32'd0);
        chk("rs_valid", {31'd0, out_valid}, 32'd0);
        chk("rs_rd", {27'd0, out_rd}, 32'd0);
        reset = 1'b0; #1;
        chk("rs_ready_after", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("rs_issue_valid", {31'd0, out_valid}, 32'd1);
        chk("rs_issue_rd", {27'd0, out_rd}, 32'd6);
        chk("rs_issue_rs1", out_rs1_val, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
